// File: rtl/imem_prefetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_prefetch_queue_if
// Purpose  : imem request/response and fetch-stage handshake bundle.
// Revision : 1.0  initial release
// ============================================================================
interface imem_prefetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_insn;
    logic [31:0] fetch_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Prefetch queue side
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output fetch_valid,
        output fetch_insn,
        output fetch_pc,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  fetch_ready,
        input  redirect,
        input  redirect_pc
    );

    // imem / fetch / execute side
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  fetch_valid,
        input  fetch_insn,
        input  fetch_pc,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output fetch_ready,
        output redirect,
        output redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/imem_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : imem_prefetch_queue
// Purpose  : Credit-limited instruction prefetch FIFO with PC tags and flush.
// Revision : 1.0  initial release
// ============================================================================
module imem_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                  clock,
    input  logic                  reset,
    imem_prefetch_queue_if.master bus
);
    localparam int c_PW  = $clog2(DEPTH);
    localparam int c_CW  = c_PW + 1;
    localparam int c_CW1 = c_CW + 1;
    localparam logic [c_CW:0] c_DEPTH_EXT = c_CW1'(DEPTH);

    logic [31:0]     r_tag_mem  [DEPTH];
    logic [63:0]     r_data_mem [DEPTH];
    logic [c_PW-1:0] r_tag_wr;
    logic [c_PW-1:0] r_tag_rd;
    logic [c_PW-1:0] r_dat_wr;
    logic [c_PW-1:0] r_dat_rd;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_drop;
    logic [31:0]     r_next_pc;

    logic            w_credit;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_resp_live;
    logic            w_push;
    logic            w_pop;
    logic            w_fetch_valid;
    logic [63:0]     w_head;
    logic [c_CW-1:0] w_resp_ext;

    // Outstanding words plus buffered words never exceed DEPTH, so every
    // response always has a free FIFO slot waiting for it.
    always_comb begin
        w_credit      = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_DEPTH_EXT;
        w_req_valid   = w_credit & ~bus.redirect & reset;
        w_req_fire    = w_req_valid & bus.imem_req_ready;
        w_resp_live   = bus.imem_resp_valid & (r_drop == '0);
        w_push        = w_resp_live & ~bus.redirect;
        w_fetch_valid = (r_count != '0);
        w_pop         = w_fetch_valid & bus.fetch_ready;
        w_head        = r_data_mem[r_dat_rd];
        w_resp_ext    = c_CW'(bus.imem_resp_valid);
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_next_pc;
    assign bus.fetch_valid    = w_fetch_valid;
    assign bus.fetch_pc       = w_fetch_valid ? w_head[63:32] : 32'd0;
    assign bus.fetch_insn     = w_fetch_valid ? w_head[31:0]  : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_next_pc     <= RESET_PC;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_dat_wr      <= '0;
            r_dat_rd      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            // Dropped words keep holding credit until imem hands them back.
            r_outstanding <= r_outstanding + c_CW'(w_req_fire) - w_resp_ext;
            if (bus.redirect) begin
                r_next_pc <= bus.redirect_pc;
                r_tag_wr  <= '0;
                r_tag_rd  <= '0;
                r_dat_wr  <= '0;
                r_dat_rd  <= '0;
                r_count   <= '0;
                r_drop    <= r_outstanding - w_resp_ext;
            end else begin
                if (w_req_fire) begin
                    r_next_pc <= r_next_pc + 32'd1;
                    r_tag_wr  <= r_tag_wr + c_PW'(1);
                end
                if (w_resp_live) begin
                    r_tag_rd <= r_tag_rd + c_PW'(1);
                end
                if (bus.imem_resp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - c_CW'(1);
                end
                if (w_push) begin
                    r_dat_wr <= r_dat_wr + c_PW'(1);
                end
                if (w_pop) begin
                    r_dat_rd <= r_dat_rd + c_PW'(1);
                end
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_req_fire) begin
            r_tag_mem[r_tag_wr] <= r_next_pc;
        end
        if (w_push) begin
            r_data_mem[r_dat_wr] <= {r_tag_mem[r_tag_rd], bus.imem_resp_data};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_imem_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_prefetch_queue
// Purpose  : Bench for imem_prefetch_queue with an in-order imem and queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic clock = 1'b0;
    logic rst_n = 1'b1;
    always #5 clock = ~clock;

    imem_prefetch_queue_if bus ();

    imem_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int unsigned lat_min   = 1;
    int unsigned lat_max   = 1;
    int unsigned pct_rdy   = 100;
    int unsigned pct_frdy  = 100;
    int unsigned pml_redir = 0;
    bit          want_redir = 1'b0;
    logic [31:0] want_redir_pc = 32'd0;

    // Model: pending imem words (with live flag) and the fetch-visible queue
    logic [31:0] pend_addr [$];
    longint      pend_due  [$];
    bit          pend_live [$];
    logic [31:0] mq        [$];
    logic [31:0] m_next_pc = RESET_PC;
    longint      cyc       = 0;
    longint      last_due  = 0;

    int          n_req     = 0;
    logic        obs_fv    = 1'b0;
    logic [31:0] obs_fpc   = 32'd0;
    logic        obs_ffire = 1'b0;

    function automatic logic [31:0] image(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; runs exactly one clock cycle.
    task automatic cycle();
        logic        rv;
        logic        rd;
        logic        exp_req;
        logic        exp_fv;
        logic        req_fire;
        logic        fetch_fire;
        logic [31:0] rpc;
        longint      due;
        rv = (pend_due.size() != 0) && (pend_due[0] == cyc + 1);
        bus.imem_resp_valid = rv;
        bus.imem_resp_data  = rv ? image(pend_addr[0]) : $urandom;
        bus.imem_req_ready  = ($urandom_range(99) < pct_rdy);
        bus.fetch_ready     = ($urandom_range(99) < pct_frdy);
        rd = want_redir || ($urandom_range(999) < pml_redir);
        if (want_redir) begin
            rpc = want_redir_pc;
        end else begin
            case ($urandom_range(2))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFFE;
                default: rpc = 32'h0000_0040;
            endcase
        end
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        want_redir      = 1'b0;

        @(negedge clock);
        exp_req = ((pend_due.size() + mq.size()) < DEPTH) && !rd;
        exp_fv  = (mq.size() != 0);
        chk("req_valid", bus.imem_req_valid, exp_req);
        chk("req_addr", bus.imem_req_addr, m_next_pc);
        chk("fetch_valid", bus.fetch_valid, exp_fv);
        if (exp_fv) begin
            chk("fetch_pc", bus.fetch_pc, mq[0]);
            chk("fetch_insn", bus.fetch_insn, image(mq[0]));
        end
        obs_fv    = bus.fetch_valid;
        obs_fpc   = bus.fetch_pc;
        obs_ffire = bus.fetch_valid & bus.fetch_ready;
        if (bus.imem_req_valid && bus.imem_req_ready) n_req++;
        req_fire   = exp_req & bus.imem_req_ready;
        fetch_fire = exp_fv & bus.fetch_ready;

        @(posedge clock);
        cyc++;
        if (fetch_fire) void'(mq.pop_front());
        if (rv) begin
            if (pend_live[0] && !rd) mq.push_back(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            void'(pend_live.pop_front());
        end
        if (rd) begin
            mq.delete();
            foreach (pend_live[i]) pend_live[i] = 1'b0;
            m_next_pc = rpc;
        end
        if (req_fire) begin
            due = cyc + longint'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            pend_addr.push_back(m_next_pc);
            pend_due.push_back(due);
            pend_live.push_back(1'b1);
            last_due  = due;
            m_next_pc = m_next_pc + 32'd1;
        end
        #1;
    endtask

    // Asynchronous reset pulse between edges; imem is reset alongside.
    task automatic do_reset_mid();
        #2;
        rst_n = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.redirect        = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.fetch_ready     = 1'b1;
        #1;
        chk("rst_fetch_valid", bus.fetch_valid, 32'd0);
        chk("rst_fetch_pc", bus.fetch_pc, 32'd0);
        chk("rst_fetch_insn", bus.fetch_insn, 32'd0);
        chk("rst_req_valid", bus.imem_req_valid, 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
        mq.delete();
        pend_addr.delete();
        pend_due.delete();
        pend_live.delete();
        m_next_pc = RESET_PC;
        @(posedge clock);
        cyc++;
        last_due = cyc;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'd0;
        bus.fetch_ready     = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_pc     = 32'd0;
        #1 rst_n = 1'b0;
        @(posedge clock);
        cyc++;
        last_due = cyc;
        #1;
        chk("init_fetch_valid", bus.fetch_valid, 32'd0);
        chk("init_fetch_pc", bus.fetch_pc, 32'd0);
        chk("init_fetch_insn", bus.fetch_insn, 32'd0);
        chk("init_req_valid", bus.imem_req_valid, 32'd0);
        chk("init_req_addr", bus.imem_req_addr, RESET_PC);
        rst_n = 1'b1;

        // Streaming at latency 1 with fetch always ready
        lat_min = 1; lat_max = 1; pct_rdy = 100; pct_frdy = 100; pml_redir = 0;
        n_req = 0;
        repeat (24) cycle();
        chk("stream_req_count", n_req, 32'd24);

        // Stalled fetch: credit fills exactly DEPTH, one pop frees one slot
        do_reset_mid();
        pct_frdy = 0; n_req = 0;
        repeat (12) cycle();
        chk("full_req_count", n_req, DEPTH);
        chk("full_fetch_valid", obs_fv, 32'd1);
        pct_frdy = 100;
        cycle();
        chk("full_single_pop", obs_ffire, 32'd1);
        pct_frdy = 0; n_req = 0;
        repeat (8) cycle();
        chk("refill_req_count", n_req, 32'd1);

        // Latency 3, redirect with three words in flight
        do_reset_mid();
        lat_min = 3; lat_max = 3; pct_frdy = 100;
        for (int k = 0; k < 20 && pend_due.size() != 3; k++) cycle();
        chk("lat3_outstanding", pend_due.size(), 32'd3);
        want_redir = 1'b1; want_redir_pc = 32'h0000_0040;
        cycle();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle();
            if (obs_fv === 1'b1) found = 1'b1;
        end
        chk("lat3_fetch_seen", found, 32'd1);
        chk("lat3_first_pc", obs_fpc, 32'h0000_0040);

        // Redirect coinciding with a fetch handshake and a returning word
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mq.size() != 0 && pend_due.size() != 0 && pend_due[0] == cyc + 1) found = 1'b1;
            else cycle();
        end
        chk("coinc_setup", found, 32'd1);
        want_redir = 1'b1; want_redir_pc = 32'h0000_0200;
        cycle();
        chk("coinc_handshake", obs_ffire, 32'd1);
        cycle();
        chk("coinc_empty_after", obs_fv, 32'd0);

        // Random backpressure, latency and redirects, including an address wrap
        lat_min = 1; lat_max = 4; pct_rdy = 50; pct_frdy = 60; pml_redir = 20;
        want_redir = 1'b1; want_redir_pc = 32'hFFFF_FFFD;
        repeat (500) cycle();
        lat_min = 1; lat_max = 1; pct_rdy = 70; pct_frdy = 50; pml_redir = 5;
        repeat (300) cycle();

        // Reset in mid-stream, then a clean restart from RESET_PC
        lat_min = 1; lat_max = 3; pct_rdy = 80; pct_frdy = 70; pml_redir = 10;
        repeat (30) cycle();
        do_reset_mid();
        pct_rdy = 100; pct_frdy = 100; pml_redir = 0;
        repeat (40) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
